instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Streaming instruction encoder, the inverse of the pipeline's instruction decoder. It accepts decoded-field descriptors over a valid/ready handshake, packs each into a 16-bit instruction word, and writes the words sequentially into instruction memory from a programmable base address. It is used by the boot/debug loader and the self-test sequencer to build programs in IMEM without a host-side assembler.

Parameters:
ADDR_W, 8, IMEM word-address width; addresses 0 .. 2^ADDR_W-1

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  pulse; loads base_addr, clears flags, enters RUN
base_addr  in  ADDR_W  first IMEM address to write
in_valid  in  1  descriptor valid
in_ready  out  1  descriptor accepted when in_valid && in_ready
in_cls  in  2  00 mem, 01 alu, 10 jump, 11 reserved (illegal)
in_store  in  1  mem class: 1 = ST, 0 = LD
in_op  in  4  alu op (alu class); [2:0] = condition (jump class)
in_rd  in  3  LD dest / ST data reg / alu dest / JMP target reg
in_rs1  in  3  mem base / alu A / branch A
in_rs2  in  3  alu B / branch B
in_imm  in  16  unsigned immediate (mem offset, alu op 1010 imm)
in_last  in  1  final descriptor of program
im_we  out  1  IMEM write strobe
im_addr  out  ADDR_W  IMEM write address
im_wdata  out  16  encoded instruction
im_ready  in  1  IMEM accepts write when im_we && im_ready
busy  out  1  state is RUN or FLUSH
done  out  1  one-cycle pulse when the last word has been written
err  out  1  sticky illegal/overflow flag, cleared by start or rst
err_code  out  2  00 none, 01 reserved class, 10 immediate out of range, 11 address overflow
word_count  out  ADDR_W+1  words written since start

Behaviour:
- Reset: state IDLE; in_ready, im_we, done, err, busy = 0; im_addr, im_wdata, err_code, word_count = 0.
- FSM states: IDLE, RUN, FLUSH, ERR. start is honoured in every state and has priority over all other events.
- start: addr_ctr <= base_addr; word_count, err, err_code <= 0; any pending write is dropped; next state RUN.
- RUN: in_ready = !wr_pend || im_ready, where wr_pend is a 1-deep output register.
- Acceptance: the descriptor is encoded combinationally and registered into im_wdata/im_addr, im_we = 1 on the next cycle (latency 1). im_we, im_addr and im_wdata hold stable until im_ready. On the handshake: addr_ctr += 1 and word_count += 1.
- Back-to-back: a new acceptance may coincide with im_ready, giving one word per cycle at full throughput.
- Encoding, mem class: [15:14]=00, [13]=in_store, [12:10]=in_rd, [9:7]=in_rs1, [6:0]=in_imm[6:0]. Requires in_imm < 128.
- Encoding, alu class: [15:14]=01, [13:10]=in_op, [9]=0, [8:6]=in_rd. For in_op==1010, [5:0]=in_imm[5:0] and in_imm must be < 64. For other ops, [5:3]=in_rs1 and [2:0]=in_rs2.
- Encoding, jump class: [15:14]=10, [13:11]=in_op[2:0].
  - Condition 111 (NOP): all remaining bits 0.
  - Condition 110 (JMP): [4:2]=in_rd, other bits 0.
  - Otherwise: [10:8]=in_rs1, [7:5]=in_rs2, [4:0]=0.
- Illegal descriptor (class 11 or immediate out of range): accepted (handshake completes) but not written. err=1, err_code set, next state ERR.
- Address overflow: a descriptor accepted while addr_ctr has already wrapped past 2^ADDR_W-1 sets err_code 11 and is not written. The address never wraps silently.
- in_last accepted and legal: next state FLUSH, in_ready=0. When the pending write completes, done pulses for 1 cycle and state returns to IDLE.
- ERR: in_ready=0, no writes; the pending legal write from the previous descriptor still completes. Exit only via start or rst.
- IDLE: in_ready=0, im_we=0 once drained. Descriptors presented in IDLE are ignored.
- rst mid-write: the write is abandoned immediately and im_we drops in the same cycle.

Decomposition:
- Package isa_pkg holds:
  - class codes (CLS_MEM, CLS_ALU, CLS_JMP, CLS_RSV)
  - ALU_ADD and ALU_IMM (4'b1010)
  - jump conditions (JC_JMP=110, JC_NOP=111)
  - err_code constants
  - field bit-position constants, shared with the decoder
- Sub-module instr_pack: purely combinational descriptor-to-word packer that also produces the legality flag and error code. The encoder FSM, address counter and output register live in instr_encoder.

Test Plan:
- start base=0x10; LD rd=3, rs1=2, imm=5 -> im_we at 0x10, wdata 0x0D05; ST rd=1, rs1=4, imm=0x7F -> 0x11, wdata 0x267F.
- ALU op=0011 rd=5 rs1=6 rs2=7 -> 0x4D77; ALU op=1010 rd=2 imm=0x2A -> 0x68AA.
- JMP rd=6 -> 0xB018; NOP -> 0xB800; branch cond=001 rs1=1 rs2=2 -> 0x8940, with in_last -> done pulse, word_count=3.
- im_ready held low 4 cycles mid-stream -> in_ready=0, im_addr/im_wdata stable, no word lost or duplicated.
- LD with imm=128 -> no write, err=1, err_code=10, in_ready=0 until next start; class 11 -> err_code=01.
- ADDR_W=8, base=0xFF: two descriptors -> first written at 0xFF, second gives err_code=11 with no write; rst asserted during a pending write -> im_we=0 next cycle.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder and decoder.
// Holds class codes, opcodes, error codes and instruction field positions.
package isa_pkg;

  typedef enum logic [1:0] {
    CLS_MEM = 2'b00,
    CLS_ALU = 2'b01,
    CLS_JMP = 2'b10,
    CLS_RSV = 2'b11
  } cls_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_IMM = 4'b1010;

  localparam logic [2:0] JC_JMP = 3'b110;
  localparam logic [2:0] JC_NOP = 3'b111;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_RSV  = 2'b01,
    ERR_IMM  = 2'b10,
    ERR_OVF  = 2'b11
  } err_e;

  // Instruction field positions, common to encoder and decoder
  localparam int unsigned CLS_LSB     = 14;
  localparam int unsigned MEM_ST_BIT  = 13;
  localparam int unsigned MEM_RD_LSB  = 10;
  localparam int unsigned MEM_RS1_LSB = 7;
  localparam int unsigned MEM_IMM_W   = 7;
  localparam int unsigned ALU_OP_LSB  = 10;
  localparam int unsigned ALU_RD_LSB  = 6;
  localparam int unsigned ALU_RS1_LSB = 3;
  localparam int unsigned ALU_RS2_LSB = 0;
  localparam int unsigned ALU_IMM_W   = 6;
  localparam int unsigned JC_LSB      = 11;
  localparam int unsigned JB_RS1_LSB  = 8;
  localparam int unsigned JB_RS2_LSB  = 5;
  localparam int unsigned JT_RD_LSB   = 2;

  typedef struct packed {
    cls_e        cls;
    logic        store;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;
  } desc_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational descriptor-to-instruction packer with legality check.
module instr_pack
  import isa_pkg::*;
(
  input  desc_t       desc_i,
  output logic [15:0] word_o,
  output logic        legal_o,
  output err_e        err_o
);

  always_comb begin
    word_o = '0;
    err_o  = ERR_NONE;
    word_o[CLS_LSB +: 2] = desc_i.cls;
    unique case (desc_i.cls)
      CLS_MEM: begin
        word_o[MEM_ST_BIT]           = desc_i.store;
        word_o[MEM_RD_LSB +: 3]      = desc_i.rd;
        word_o[MEM_RS1_LSB +: 3]     = desc_i.rs1;
        word_o[0 +: MEM_IMM_W]       = desc_i.imm[MEM_IMM_W-1:0];
        if (|desc_i.imm[15:MEM_IMM_W]) err_o = ERR_IMM;
      end
      CLS_ALU: begin
        word_o[ALU_OP_LSB +: 4] = desc_i.op;
        word_o[ALU_RD_LSB +: 3] = desc_i.rd;
        if (desc_i.op == ALU_IMM) begin
          word_o[0 +: ALU_IMM_W] = desc_i.imm[ALU_IMM_W-1:0];
          if (|desc_i.imm[15:ALU_IMM_W]) err_o = ERR_IMM;
        end else begin
          word_o[ALU_RS1_LSB +: 3] = desc_i.rs1;
          word_o[ALU_RS2_LSB +: 3] = desc_i.rs2;
        end
      end
      CLS_JMP: begin
        word_o[JC_LSB +: 3] = desc_i.op[2:0];
        case (desc_i.op[2:0])
          JC_NOP:  word_o[JC_LSB-1:0] = '0;
          JC_JMP:  word_o[JT_RD_LSB +: 3] = desc_i.rd;
          default: begin
            word_o[JB_RS1_LSB +: 3] = desc_i.rs1;
            word_o[JB_RS2_LSB +: 3] = desc_i.rs2;
          end
        endcase
      end
      default: err_o = ERR_RSV;
    endcase
  end

  assign legal_o = (err_o == ERR_NONE);

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: packs descriptors and writes them to IMEM
// sequentially from a programmable base address.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_cls,
  input  logic              in_store,
  input  logic [3:0]        in_op,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_rs1,
  input  logic [2:0]        in_rs2,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_wdata,
  input  logic              im_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_ERR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   addr_ctr_q, addr_ctr_d;
  logic              wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [15:0]       im_wdata_q, im_wdata_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              err_q, err_d;
  err_e              err_code_q, err_code_d;
  logic              done_q, done_d;

  desc_t       desc;
  logic [15:0] pk_word;
  logic        pk_legal;
  err_e        pk_err;
  logic        accept, wr_done, overflow;

  always_comb begin
    desc       = '0;
    desc.cls   = cls_e'(in_cls);
    desc.store = in_store;
    desc.op    = in_op;
    desc.rd    = in_rd;
    desc.rs1   = in_rs1;
    desc.rs2   = in_rs2;
    desc.imm   = in_imm;
  end

  instr_pack u_pack (
    .desc_i  (desc),
    .word_o  (pk_word),
    .legal_o (pk_legal),
    .err_o   (pk_err)
  );

  assign im_we    = wr_pend_q && !rst;
  assign wr_done  = im_we && im_ready;
  assign in_ready = (state_q == S_RUN) && !start && (!wr_pend_q || im_ready);
  assign accept   = in_valid && in_ready;
  assign overflow = addr_ctr_q[ADDR_W];

  // addr_ctr tracks the next address to allocate; since the output register is
  // one deep this equals the handshake-advanced address of the next word.
  always_comb begin
    state_d      = state_q;
    addr_ctr_d   = addr_ctr_q;
    wr_pend_d    = wr_pend_q;
    im_addr_d    = im_addr_q;
    im_wdata_d   = im_wdata_q;
    word_count_d = word_count_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    done_d       = 1'b0;

    if (wr_done) begin
      wr_pend_d    = 1'b0;
      word_count_d = word_count_q + 1'b1;
      if (state_q == S_FLUSH) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end

    if (accept) begin
      if (!pk_legal) begin
        err_d      = 1'b1;
        err_code_d = pk_err;
        state_d    = S_ERR;
      end else if (overflow) begin
        err_d      = 1'b1;
        err_code_d = ERR_OVF;
        state_d    = S_ERR;
      end else begin
        wr_pend_d  = 1'b1;
        im_addr_d  = addr_ctr_q[ADDR_W-1:0];
        im_wdata_d = pk_word;
        addr_ctr_d = addr_ctr_q + 1'b1;
        if (in_last) state_d = S_FLUSH;
      end
    end

    if (start) begin
      state_d      = S_RUN;
      addr_ctr_d   = {1'b0, base_addr};
      wr_pend_d    = 1'b0;
      word_count_d = '0;
      err_d        = 1'b0;
      err_code_d   = ERR_NONE;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_ctr_q   <= '0;
      wr_pend_q    <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      word_count_q <= '0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_ctr_q   <= addr_ctr_d;
      wr_pend_q    <= wr_pend_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      done_q       <= done_d;
    end
  end

  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;
  assign word_count = word_count_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign done       = done_q;
  assign busy       = (state_q == S_RUN) || (state_q == S_FLUSH);

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected IMEM writes are queued on
// descriptor acceptance and matched against observed write handshakes.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, in_store, in_last;
  logic [7:0]  base_addr, im_addr;
  logic [1:0]  in_cls, err_code;
  logic [3:0]  in_op;
  logic [2:0]  in_rd, in_rs1, in_rs2;
  logic [15:0] in_imm, im_wdata;
  logic        im_we, im_ready, busy, done, err;
  logic [8:0]  word_count;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] sb_q[$];
  logic [23:0] sb_e;
  logic [8:0]  exp_addr;
  logic [1:0]  exp_code;
  logic        rnd_rdy = 1'b0;

  instr_encoder #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cls     (in_cls),
    .in_store   (in_store),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .im_ready   (im_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference encoding; returns {err_code, word}
  function automatic logic [17:0] model(input logic [1:0] cls, input logic st,
      input logic [3:0] op, input logic [2:0] rd, rs1, rs2, input logic [15:0] imm);
    logic [15:0] w;
    logic [1:0]  e;
    w = '0;
    e = 2'b00;
    case (cls)
      2'b00: begin
        w = {2'b00, st, rd, rs1, imm[6:0]};
        if (imm > 16'd127) e = 2'b10;
      end
      2'b01: begin
        if (op == 4'b1010) begin
          w = {2'b01, op, 1'b0, rd, imm[5:0]};
          if (imm > 16'd63) e = 2'b10;
        end else begin
          w = {2'b01, op, 1'b0, rd, rs1, rs2};
        end
      end
      2'b10: begin
        if (op[2:0] == 3'b111)      w = {2'b10, 3'b111, 11'b0};
        else if (op[2:0] == 3'b110) w = {2'b10, 3'b110, 6'b0, rd, 2'b00};
        else                        w = {2'b10, op[2:0], rs1, rs2, 5'b0};
      end
      default: e = 2'b01;
    endcase
    return {e, w};
  endfunction

  always @(negedge clk) begin
    if (im_we && im_ready) begin
      chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        sb_e = sb_q.pop_front();
        chk("wr_addr", im_addr, sb_e[23:16]);
        chk("wr_data", im_wdata, sb_e[15:0]);
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1 im_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic do_start(input logic [7:0] b);
    base_addr = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    exp_addr = {1'b0, b};
    exp_code = 2'b00;
  endtask

  task automatic send(input logic [1:0] cls, input logic st, input logic [3:0] op,
      input logic [2:0] rd, rs1, rs2, input logic [15:0] imm, input logic last);
    logic [17:0]  m;
    logic         acc;
    int unsigned  n;
    in_cls = cls; in_store = st; in_op = op; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 60) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else n++;
    end
    chk("accept_wait", 32'(acc), 1);
    if (acc) begin
      m = model(cls, st, op, rd, rs1, rs2, imm);
      if (m[17:16] == 2'b00 && exp_addr[8]) m[17:16] = 2'b11;
      if (m[17:16] == 2'b00) begin
        sb_q.push_back({exp_addr[7:0], m[15:0]});
        exp_addr = exp_addr + 9'd1;
      end else begin
        exp_code = m[17:16];
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb_q.size(), 0);
  endtask

  task automatic wait_done(input logic [8:0] exp_wc);
    logic        seen;
    int unsigned n;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      n++;
    end
    chk("done_pulse", 32'(seen), 1);
    @(negedge clk);
    chk("done_1cyc", 32'(done), 0);
    chk("busy_after_done", 32'(busy), 0);
    chk("word_count", word_count, exp_wc);
    chk("sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [8:0] n_rand;
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_cls = '0;
    in_store = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_last = 1'b0; im_ready = 1'b1;
    exp_addr = '0; exp_code = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_im_we", 32'(im_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_im_addr", im_addr, 0);
    chk("rst_im_wdata", im_wdata, 0);
    @(posedge clk); #1;

    // Program A: mem/alu words at full throughput
    do_start(8'h10);
    send(2'b00, 1'b0, 4'h0, 3'd3, 3'd2, 3'd0, 16'd5, 1'b0);
    send(2'b00, 1'b1, 4'h0, 3'd1, 3'd4, 3'd0, 16'h7F, 1'b0);
    send(2'b01, 1'b0, 4'b0011, 3'd5, 3'd6, 3'd7, 16'd0, 1'b0);
    send(2'b01, 1'b0, 4'b1010, 3'd2, 3'd0, 3'd0, 16'h2A, 1'b1);
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 0);
    wait_done(9'd4);
    in_valid = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1 in_valid = 1'b0;

    // Program B: jump class
    do_start(8'h20);
    send(2'b10, 1'b0, 4'b0110, 3'd6, 3'd0, 3'd0, 16'd0, 1'b0);
    send(2'b10, 1'b0, 4'b0111, 3'd0, 3'd0, 3'd0, 16'd0, 1'b0);
    send(2'b10, 1'b0, 4'b0001, 3'd0, 3'd1, 3'd2, 16'd0, 1'b1);
    wait_done(9'd3);

    // Stall: IMEM not ready for 4 cycles with a second descriptor waiting
    do_start(8'h40);
    im_ready = 1'b0;
    send(2'b00, 1'b0, 4'h0, 3'd3, 3'd2, 3'd0, 16'd5, 1'b0);
    in_cls = 2'b01; in_op = 4'b1010; in_rd = 3'd7; in_imm = 16'd63; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_im_we", 32'(im_we), 1);
      chk("stall_im_addr", im_addr, 8'h40);
      chk("stall_im_wdata", im_wdata, 16'h0D05);
    end
    @(posedge clk); #1 im_ready = 1'b1;
    send(2'b01, 1'b0, 4'b1010, 3'd7, 3'd0, 3'd0, 16'd63, 1'b1);
    wait_done(9'd2);

    // Program C: random legal descriptors with random IMEM backpressure
    do_start(8'h80);
    rnd_rdy = 1'b1;
    n_rand = 9'd10;
    for (int i = 0; i < 10; i++) begin
      send(2'($urandom_range(0, 2)), 1'($urandom), 4'($urandom), 3'($urandom),
           3'($urandom), 3'($urandom), 16'($urandom_range(0, 63)), 1'(i == 9));
    end
    wait_done(n_rand);
    rnd_rdy = 1'b0;
    @(posedge clk); #1 im_ready = 1'b1;

    // Immediate out of range on LD
    do_start(8'h00);
    send(2'b00, 1'b0, 4'h0, 3'd3, 3'd2, 3'd0, 16'd128, 1'b0);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("imm_err", {31'b0, err}, 1);
      chk("imm_err_code", err_code, exp_code);
      chk("imm_in_ready", 32'(in_ready), 0);
      chk("imm_im_we", 32'(im_we), 0);
    end
    @(posedge clk); #1 in_valid = 1'b0;

    do_start(8'h00);
    @(negedge clk);
    chk("start_clr_err", {31'b0, err}, 0);
    chk("start_clr_code", err_code, 0);
    @(posedge clk); #1;
    send(2'b01, 1'b0, 4'b1010, 3'd1, 3'd0, 3'd0, 16'd64, 1'b0);
    @(negedge clk);
    chk("aluimm_err_code", err_code, exp_code);

    // Reserved class
    @(posedge clk); #1;
    do_start(8'h00);
    send(2'b11, 1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 16'd0, 1'b0);
    @(negedge clk);
    chk("rsv_err", {31'b0, err}, 1);
    chk("rsv_err_code", err_code, exp_code);
    chk("rsv_word_count", word_count, 0);

    // Address overflow at the top of IMEM
    @(posedge clk); #1;
    do_start(8'hFF);
    send(2'b00, 1'b0, 4'h0, 3'd1, 3'd1, 3'd0, 16'd1, 1'b0);
    send(2'b00, 1'b0, 4'h0, 3'd2, 3'd2, 3'd0, 16'd2, 1'b0);
    drain();
    repeat (2) @(negedge clk);
    chk("ovf_err", {31'b0, err}, 1);
    chk("ovf_err_code", err_code, exp_code);
    chk("ovf_word_count", word_count, 1);
    chk("ovf_im_we", 32'(im_we), 0);

    // Reset during a pending write
    @(posedge clk); #1;
    do_start(8'h30);
    im_ready = 1'b0;
    send(2'b01, 1'b0, 4'b0011, 3'd1, 3'd2, 3'd3, 16'd0, 1'b0);
    @(negedge clk);
    chk("pend_im_we", 32'(im_we), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_drop_im_we", 32'(im_we), 0);
    sb_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    im_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_im_we", 32'(im_we), 0);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_wc", word_count, 0);
    chk("post_rst_addr", im_addr, 0);

    chk("sb_empty_end", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
